regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-requester port arbiter for the `registers` file (4 × 32-bit, 2 registered read ports, 1 masked write port). It shares the read-port pair and the write port between requester A and requester B with independent round-robin arbitration and a valid/ready request handshake. It returns read data one cycle after grant, with same-cycle write bypass. It also ensures no write ever reaches register 0.

## Interface
Parameters:
- N, 32, register data width
- M, 2, register id width (2^M registers)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_valid_a / rd_valid_b  in  1  read request valid
- rd_ready_a / rd_ready_b  out  1  read request granted this cycle (combinational)
- rd_r1_a, rd_r2_a / rd_r1_b, rd_r2_b  in  M  register ids to read
- rd_resp_a / rd_resp_b  out  1  read response valid (registered)
- rd_v1, rd_v2  out  N  response data, shared, qualified by rd_resp_a/b
- wr_valid_a / wr_valid_b  in  1  write request valid
- wr_ready_a / wr_ready_b  out  1  write request accepted this cycle (combinational)
- wr_id_a / wr_id_b  in  M  register id to write
- wr_mask_a / wr_mask_b  in  N  bit write mask
- wr_data_a / wr_data_b  in  N  write data
- wr_drop  out  1  pulse: accepted write targeted register 0 and was discarded (registered)
- rf_r1, rf_r2, rf_w1  out  M  to register file
- rf_mask, rf_w  out  N  to register file
- rf_v1, rf_v2  in  N  from register file (registered there)

## Operation
- Read and write arbitration are independent. Each has a 1-bit priority pointer: 0 = A, 1 = B.
- Grant rule, per channel:
  - Only one requester valid → that requester is granted.
  - Both valid → the pointer's requester is granted.
  - After any grant, the pointer moves to the non-granted requester.
  - No grant → the pointer holds.
- A request completes on the cycle its ready is high. No request is ever ready while its valid is low.
- Read grant: drive rf_r1/rf_r2 with the granted ids. With no grant, drive 0.
- Read response: on the cycle after a grant, rd_resp_x=1 for the granted requester only. There is no response backpressure. The requester must take the response that cycle.
- Write grant with id≠0: drive rf_w1=id, rf_mask=mask, rf_w=data.
- Write grant with id=0, or no write grant: drive rf_w1=0, rf_mask=0, rf_w=0, so the register file keeps its contents.
  - An id=0 write is still handshaken (ready=1), then wr_drop=1 the next cycle.
- Bypass:
  - The register file samples the read address and the write in the same edge, so a read granted in the same cycle as a write returns the old value.
  - The arbiter therefore registers the granted write (id, mask, data, valid; valid only if id≠0) alongside the read ids.
  - In the response cycle: rd_v1 = (rf_v1 & ~mask) | (data & mask) if the registered write is valid and its id equals the registered r1, else rf_v1. rd_v2 is formed the same way.
- A read of register 0 always returns 0. Bypass never applies to register 0.

## Timing
- Reset (asynchronous, immediate):
  - Both pointers = 0 (A first).
  - rd_resp_a/b = 0, wr_drop = 0.
  - Registered write valid = 0, registered ids = 0.
  - rf_* outputs follow the combinational rules, i.e. 0 when there is no request.
- A pending response whose grant preceded reset is lost: rd_resp stays 0 after reset deasserts.
- Read latency: grant in cycle T, data on rd_v1/rd_v2 in cycle T+1. Reads can be granted back-to-back every cycle.
- A write granted in T is visible through rf_v* to a read granted in T+1 or later. A read granted in T itself sees it through the bypass.
- Sustained throughput: 1 read and 1 write per cycle. Under continuous contention each requester gets every other grant.
- rd_ready_x, wr_ready_x and rf_* are combinational from valid inputs and pointers. rd_resp_x, wr_drop and the bypass registers are flops.

## Test plan
- Reset then idle: all ready=0, rd_resp=0, rf_mask=0 → no register-file change over 10 cycles.
- Contention: rd_valid_a=rd_valid_b=1 for 4 cycles → grants A,B,A,B. Responses one cycle later, with matching rd_resp_a/rd_resp_b.
- Write then read: A writes id 2, mask 0xFFFFFFFF, data 0xDEADBEEF in T; B reads r1=2 in T+1 → rd_v1=0xDEADBEEF at T+2.
- Bypass: reg1=0x12345678. In the same cycle, A writes id 1 with mask 0x0000FFFF, data 0xAAAAAAAA, and B reads r1=1, r2=1 → rd_v1=rd_v2=0x1234AAAA next cycle.
- Register 0 protection: A writes id 0, data 0xFFFFFFFF → wr_ready_a=1, rf_mask=0, wr_drop=1 next cycle. A subsequent read of r1=0 returns 0.
- Async reset mid-read: grant A in T, assert rst before the T+1 edge → rd_resp_a stays 0, and the pointer is back to A.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-requester arbiter for a 4-entry register file: round-robin read and write
// channels, one-cycle read response with same-cycle write bypass, and register 0
// kept write-protected and read as zero.
module regfile_arbiter #(
  parameter int unsigned N = 32,
  parameter int unsigned M = 2
) (
  input  logic         clk,
  input  logic         rst,
  // Read request channel
  input  logic         rd_valid_a,
  input  logic         rd_valid_b,
  output logic         rd_ready_a,
  output logic         rd_ready_b,
  input  logic [M-1:0] rd_r1_a,
  input  logic [M-1:0] rd_r2_a,
  input  logic [M-1:0] rd_r1_b,
  input  logic [M-1:0] rd_r2_b,
  output logic         rd_resp_a,
  output logic         rd_resp_b,
  output logic [N-1:0] rd_v1,
  output logic [N-1:0] rd_v2,
  // Write request channel
  input  logic         wr_valid_a,
  input  logic         wr_valid_b,
  output logic         wr_ready_a,
  output logic         wr_ready_b,
  input  logic [M-1:0] wr_id_a,
  input  logic [M-1:0] wr_id_b,
  input  logic [N-1:0] wr_mask_a,
  input  logic [N-1:0] wr_mask_b,
  input  logic [N-1:0] wr_data_a,
  input  logic [N-1:0] wr_data_b,
  output logic         wr_drop,
  // Register file side
  output logic [M-1:0] rf_r1,
  output logic [M-1:0] rf_r2,
  output logic [M-1:0] rf_w1,
  output logic [N-1:0] rf_mask,
  output logic [N-1:0] rf_w,
  input  logic [N-1:0] rf_v1,
  input  logic [N-1:0] rf_v2
);

  // Priority pointers: 0 = A has priority, 1 = B has priority.
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_gnt_a, rd_gnt_b;
  logic         wr_gnt_a, wr_gnt_b;
  logic         wr_gnt;
  logic [M-1:0] wr_id_sel;
  logic [N-1:0] wr_mask_sel;
  logic [N-1:0] wr_data_sel;
  logic         wr_keep;

  logic         rd_resp_a_q, rd_resp_b_q;
  logic         wr_drop_q;
  logic [M-1:0] r1_q, r2_q;
  logic         byp_valid_q;
  logic [M-1:0] byp_id_q;
  logic [N-1:0] byp_mask_q;
  logic [N-1:0] byp_data_q;

  // Read arbitration, pointer update and read address mux.
  always_comb begin
    rd_gnt_a = rd_valid_a & (~rd_valid_b | ~rd_ptr_q);
    rd_gnt_b = rd_valid_b & (~rd_valid_a | rd_ptr_q);
    rd_ptr_d = rd_ptr_q;
    rf_r1    = '0;
    rf_r2    = '0;
    if (rd_gnt_a) begin
      rd_ptr_d = 1'b1;
      rf_r1    = rd_r1_a;
      rf_r2    = rd_r2_a;
    end else if (rd_gnt_b) begin
      rd_ptr_d = 1'b0;
      rf_r1    = rd_r1_b;
      rf_r2    = rd_r2_b;
    end
  end

  // Write arbitration; writes aimed at register 0 are accepted but never reach the file.
  always_comb begin
    wr_gnt_a    = wr_valid_a & (~wr_valid_b | ~wr_ptr_q);
    wr_gnt_b    = wr_valid_b & (~wr_valid_a | wr_ptr_q);
    wr_gnt      = wr_gnt_a | wr_gnt_b;
    wr_ptr_d    = wr_ptr_q;
    wr_id_sel   = '0;
    wr_mask_sel = '0;
    wr_data_sel = '0;
    if (wr_gnt_a) begin
      wr_ptr_d    = 1'b1;
      wr_id_sel   = wr_id_a;
      wr_mask_sel = wr_mask_a;
      wr_data_sel = wr_data_a;
    end else if (wr_gnt_b) begin
      wr_ptr_d    = 1'b0;
      wr_id_sel   = wr_id_b;
      wr_mask_sel = wr_mask_b;
      wr_data_sel = wr_data_b;
    end
    wr_keep = wr_gnt && (wr_id_sel != '0);
    rf_w1   = wr_keep ? wr_id_sel   : '0;
    rf_mask = wr_keep ? wr_mask_sel : '0;
    rf_w    = wr_keep ? wr_data_sel : '0;
  end

  // Pointers, response flags and the write/read snapshot used for bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_resp_a_q <= 1'b0;
      rd_resp_b_q <= 1'b0;
      wr_drop_q   <= 1'b0;
      r1_q        <= '0;
      r2_q        <= '0;
      byp_valid_q <= 1'b0;
      byp_id_q    <= '0;
      byp_mask_q  <= '0;
      byp_data_q  <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_resp_a_q <= rd_gnt_a;
      rd_resp_b_q <= rd_gnt_b;
      wr_drop_q   <= wr_gnt && (wr_id_sel == '0);
      r1_q        <= rf_r1;
      r2_q        <= rf_r2;
      byp_valid_q <= wr_keep;
      byp_id_q    <= rf_w1;
      byp_mask_q  <= rf_mask;
      byp_data_q  <= rf_w;
    end
  end

  // Response data: register 0 reads as zero, otherwise merge a same-cycle write.
  always_comb begin
    rd_v1 = rf_v1;
    rd_v2 = rf_v2;
    if (r1_q == '0) begin
      rd_v1 = '0;
    end else if (byp_valid_q && (byp_id_q == r1_q)) begin
      rd_v1 = (rf_v1 & ~byp_mask_q) | (byp_data_q & byp_mask_q);
    end
    if (r2_q == '0) begin
      rd_v2 = '0;
    end else if (byp_valid_q && (byp_id_q == r2_q)) begin
      rd_v2 = (rf_v2 & ~byp_mask_q) | (byp_data_q & byp_mask_q);
    end
  end

  assign rd_ready_a = rd_gnt_a;
  assign rd_ready_b = rd_gnt_b;
  assign wr_ready_a = wr_gnt_a;
  assign wr_ready_b = wr_gnt_b;
  assign rd_resp_a  = rd_resp_a_q;
  assign rd_resp_b  = rd_resp_b_q;
  assign wr_drop    = wr_drop_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file attached.
module tb_regfile_arbiter;

  localparam int unsigned N = 32;
  localparam int unsigned M = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_valid_a, rd_valid_b, rd_ready_a, rd_ready_b;
  logic [M-1:0] rd_r1_a, rd_r2_a, rd_r1_b, rd_r2_b;
  logic         rd_resp_a, rd_resp_b;
  logic [N-1:0] rd_v1, rd_v2;
  logic         wr_valid_a, wr_valid_b, wr_ready_a, wr_ready_b;
  logic [M-1:0] wr_id_a, wr_id_b;
  logic [N-1:0] wr_mask_a, wr_mask_b, wr_data_a, wr_data_b;
  logic         wr_drop;
  logic [M-1:0] rf_r1, rf_r2, rf_w1;
  logic [N-1:0] rf_mask, rf_w, rf_v1, rf_v2;

  logic [N-1:0] regs [4];
  int checks   = 0;
  int failures = 0;

  regfile_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .rd_valid_a(rd_valid_a), .rd_valid_b(rd_valid_b),
    .rd_ready_a(rd_ready_a), .rd_ready_b(rd_ready_b),
    .rd_r1_a(rd_r1_a), .rd_r2_a(rd_r2_a), .rd_r1_b(rd_r1_b), .rd_r2_b(rd_r2_b),
    .rd_resp_a(rd_resp_a), .rd_resp_b(rd_resp_b), .rd_v1(rd_v1), .rd_v2(rd_v2),
    .wr_valid_a(wr_valid_a), .wr_valid_b(wr_valid_b),
    .wr_ready_a(wr_ready_a), .wr_ready_b(wr_ready_b),
    .wr_id_a(wr_id_a), .wr_id_b(wr_id_b),
    .wr_mask_a(wr_mask_a), .wr_mask_b(wr_mask_b),
    .wr_data_a(wr_data_a), .wr_data_b(wr_data_b), .wr_drop(wr_drop),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_w1(rf_w1), .rf_mask(rf_mask), .rf_w(rf_w),
    .rf_v1(rf_v1), .rf_v2(rf_v2)
  );

  always #5 clk = ~clk;

  // Register file: registered reads, masked writes on the same edge. Entry 0 is left
  // holding junk so that the arbiter's own zeroing of register-0 reads is exercised.
  always @(posedge clk) begin
    if (rst) begin
      regs[0] <= 32'hBAD0_BAD0;
      regs[1] <= '0;
      regs[2] <= '0;
      regs[3] <= '0;
      rf_v1   <= '0;
      rf_v2   <= '0;
    end else begin
      rf_v1        <= regs[rf_r1];
      rf_v2        <= regs[rf_r2];
      regs[rf_w1]  <= (regs[rf_w1] & ~rf_mask) | (rf_w & rf_mask);
    end
  end

  task automatic clear_inputs();
    rd_valid_a = 0; rd_valid_b = 0;
    rd_r1_a = '0; rd_r2_a = '0; rd_r1_b = '0; rd_r2_b = '0;
    wr_valid_a = 0; wr_valid_b = 0;
    wr_id_a = '0; wr_id_b = '0;
    wr_mask_a = '0; wr_mask_b = '0; wr_data_a = '0; wr_data_b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk); #1;
    checks++;
    if ({rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b} !== 4'b0) begin
      failures++; $display("FAIL reset_ready: got %b want 0000",
                           {rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b});
    end
    checks++;
    if ({rd_resp_a, rd_resp_b, wr_drop} !== 3'b0) begin
      failures++; $display("FAIL reset_flags: got %b want 000", {rd_resp_a, rd_resp_b, wr_drop});
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++;
      if (rf_mask !== '0 || rf_w1 !== '0) begin
        failures++; $display("FAIL idle_rf cycle %0d: mask %h id %0d want 0 0", i, rf_mask, rf_w1);
      end
      checks++;
      if ({rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b, rd_resp_a, rd_resp_b, wr_drop} !== 7'b0)
      begin
        failures++; $display("FAIL idle_flags cycle %0d: got %b want 0", i,
          {rd_ready_a, rd_ready_b, wr_ready_a, wr_ready_b, rd_resp_a, rd_resp_b, wr_drop});
      end
    end
  endtask

  // Both requesters write: A, B, A. Leaves reg1=1111..., reg2=2222..., reg3=3333...
  task automatic test_write_contention();
    logic [M-1:0] exp_id [3];
    logic         exp_a  [3];
    exp_id[0] = 2'd1; exp_id[1] = 2'd2; exp_id[2] = 2'd3;
    exp_a[0]  = 1'b1; exp_a[1]  = 1'b0; exp_a[2]  = 1'b1;
    @(negedge clk);
    wr_valid_a = 1; wr_id_a = 2'd1; wr_mask_a = '1; wr_data_a = 32'h1111_1111;
    wr_valid_b = 1; wr_id_b = 2'd2; wr_mask_b = '1; wr_data_b = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (wr_ready_a !== exp_a[i] || wr_ready_b !== ~exp_a[i]) begin
        failures++; $display("FAIL wr_contention %0d: ready a=%b b=%b want a=%b", i,
                             wr_ready_a, wr_ready_b, exp_a[i]);
      end
      checks++;
      if (rf_w1 !== exp_id[i]) begin
        failures++; $display("FAIL wr_contention_id %0d: got %0d want %0d", i, rf_w1, exp_id[i]);
      end
      @(negedge clk);
      if (i == 0) begin
        wr_id_a = 2'd3; wr_data_a = 32'h3333_3333;
      end
    end
    clear_inputs();
  endtask

  task automatic test_read_contention();
    logic exp_a;
    @(negedge clk);
    rd_valid_a = 1; rd_r1_a = 2'd1; rd_r2_a = 2'd2;
    rd_valid_b = 1; rd_r1_b = 2'd3; rd_r2_b = 2'd0;
    for (int i = 0; i < 4; i++) begin
      exp_a = (i % 2 == 0);
      #1;
      checks++;
      if (rd_ready_a !== exp_a || rd_ready_b !== ~exp_a || rf_r1 !== (exp_a ? 2'd1 : 2'd3)) begin
        failures++; $display("FAIL rd_grant %0d: a=%b b=%b r1=%0d want a=%b", i,
                             rd_ready_a, rd_ready_b, rf_r1, exp_a);
      end
      @(negedge clk);
      checks++;
      if (rd_resp_a !== exp_a || rd_resp_b !== ~exp_a) begin
        failures++; $display("FAIL rd_resp %0d: a=%b b=%b want a=%b", i, rd_resp_a, rd_resp_b, exp_a);
      end
      checks++;
      if (rd_v1 !== (exp_a ? 32'h1111_1111 : 32'h3333_3333) ||
          rd_v2 !== (exp_a ? 32'h2222_2222 : 32'h0)) begin
        failures++; $display("FAIL rd_data %0d: v1=%h v2=%h (granted a=%b)", i, rd_v1, rd_v2, exp_a);
      end
    end
    clear_inputs();
  endtask

  task automatic test_write_then_read();
    wr_valid_a = 1; wr_id_a = 2'd2; wr_mask_a = 32'hFFFF_FFFF; wr_data_a = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (wr_ready_a !== 1'b1 || rf_w !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wtr_write: ready=%b w=%h want 1 deadbeef", wr_ready_a, rf_w);
    end
    @(negedge clk);
    clear_inputs();
    rd_valid_b = 1; rd_r1_b = 2'd2; rd_r2_b = 2'd0;
    #1;
    checks++;
    if (rd_ready_b !== 1'b1 || rd_ready_a !== 1'b0) begin
      failures++; $display("FAIL wtr_grant: a=%b b=%b want a=0 b=1", rd_ready_a, rd_ready_b);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (rd_resp_b !== 1'b1 || rd_resp_a !== 1'b0 || rd_v1 !== 32'hDEAD_BEEF || rd_v2 !== '0) begin
      failures++; $display("FAIL wtr_data: resp a=%b b=%b v1=%h v2=%h want 0 1 deadbeef 0",
                           rd_resp_a, rd_resp_b, rd_v1, rd_v2);
    end
  endtask

  task automatic test_bypass();
    wr_valid_a = 1; wr_id_a = 2'd1; wr_mask_a = '1; wr_data_a = 32'h1234_5678;
    @(negedge clk);
    wr_mask_a = 32'h0000_FFFF; wr_data_a = 32'hAAAA_AAAA;
    rd_valid_b = 1; rd_r1_b = 2'd1; rd_r2_b = 2'd1;
    #1;
    checks++;
    if (wr_ready_a !== 1'b1 || rd_ready_b !== 1'b1 || rf_mask !== 32'h0000_FFFF) begin
      failures++; $display("FAIL byp_grant: wr=%b rd=%b mask=%h want 1 1 0000ffff",
                           wr_ready_a, rd_ready_b, rf_mask);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (rd_resp_b !== 1'b1 || rd_v1 !== 32'h1234_AAAA || rd_v2 !== 32'h1234_AAAA) begin
      failures++; $display("FAIL byp_data: resp=%b v1=%h v2=%h want 1 1234aaaa 1234aaaa",
                           rd_resp_b, rd_v1, rd_v2);
    end
    rd_valid_a = 1; rd_r1_a = 2'd1; rd_r2_a = 2'd3;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (rd_resp_a !== 1'b1 || rd_v1 !== 32'h1234_AAAA || rd_v2 !== 32'h3333_3333) begin
      failures++; $display("FAIL byp_after: resp=%b v1=%h v2=%h want 1 1234aaaa 33333333",
                           rd_resp_a, rd_v1, rd_v2);
    end
  endtask

  task automatic test_reg0();
    wr_valid_a = 1; wr_id_a = 2'd0; wr_mask_a = '1; wr_data_a = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (wr_ready_a !== 1'b1 || rf_mask !== '0 || rf_w !== '0 || rf_w1 !== '0) begin
      failures++; $display("FAIL reg0_write: ready=%b mask=%h w=%h id=%0d want 1 0 0 0",
                           wr_ready_a, rf_mask, rf_w, rf_w1);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (wr_drop !== 1'b1) begin
      failures++; $display("FAIL reg0_drop: got %b want 1", wr_drop);
    end
    rd_valid_a = 1; rd_r1_a = 2'd0; rd_r2_a = 2'd1;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (wr_drop !== 1'b0 || rd_v1 !== '0 || rd_v2 !== 32'h1234_AAAA) begin
      failures++; $display("FAIL reg0_read: drop=%b v1=%h v2=%h want 0 0 1234aaaa",
                           wr_drop, rd_v1, rd_v2);
    end
  endtask

  task automatic test_async_reset();
    // Read pointer now favours B; a reset must put it back on A.
    rd_valid_a = 1; rd_r1_a = 2'd1;
    #1;
    checks++;
    if (rd_ready_a !== 1'b1) begin
      failures++; $display("FAIL arst_grant: got %b want 1", rd_ready_a);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    checks++;
    if (rd_resp_a !== 1'b0 || rd_resp_b !== 1'b0) begin
      failures++; $display("FAIL arst_resp_in_reset: a=%b b=%b want 0 0", rd_resp_a, rd_resp_b);
    end
    @(negedge clk);
    checks++;
    if (rd_resp_a !== 1'b0) begin
      failures++; $display("FAIL arst_resp_after: got %b want 0", rd_resp_a);
    end
    rd_valid_a = 1; rd_valid_b = 1;
    #1;
    checks++;
    if (rd_ready_a !== 1'b1 || rd_ready_b !== 1'b0) begin
      failures++; $display("FAIL arst_pointer: a=%b b=%b want a=1 b=0", rd_ready_a, rd_ready_b);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (rd_resp_a !== 1'b1 || rd_resp_b !== 1'b0) begin
      failures++; $display("FAIL arst_resume: a=%b b=%b want 1 0", rd_resp_a, rd_resp_b);
    end
  endtask

  initial begin
    test_reset();
    test_write_contention();
    test_read_contention();
    @(negedge clk);
    test_write_then_read();
    test_bypass();
    test_reg0();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
